// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush and memory-stall timeout.
// Optional perf counters (stall_count, flush_count) are built when PIPELINE_CTRL_PERF_EN is defined.
//
// state    | meaning
// RUN      | normal issue; wcnt held at 0 unless the current cycle stalls on memory
// MEM_WAIT | MEM-stage access outstanding; wcnt counts consecutive stall cycles
// FAULT    | memory never answered; pipeline frozen until reset
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_write_reg_addr,
    input  logic       ex_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       ex_mem_write,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       mem_wb_bubble,
    output logic       mem_timeout
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] wcnt;
    logic [7:0] wcnt_next;
    logic [8:0] wcnt_inc;
    logic       timeout_hit;
    logic       mem_stall;
    logic       load_use;

    // Nine-bit sum so the compare stays exact even when MEM_TIMEOUT is 255.
    assign wcnt_inc    = {1'b0, wcnt} + 9'd1;
    assign timeout_hit = (wcnt_inc == 9'(MEM_TIMEOUT));

    assign mem_stall = (state != FAULT) && mem_req && !mem_ready;

    assign load_use = ex_mem_read
                   && (ex_write_reg_addr != 5'd0)
                   && ((ex_write_reg_addr == id_rs) || (ex_write_reg_addr == id_rt));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            wcnt        <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
            if (state_next == FAULT) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        case (state)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    wcnt_next  = wcnt_inc[7:0];
                    state_next = timeout_hit ? FAULT : MEM_WAIT;
                end else begin
                    // Ready or a dropped request both release the stall.
                    wcnt_next  = 8'd0;
                    state_next = RUN;
                end
            end
            FAULT: begin
                state_next = FAULT;
                wcnt_next  = wcnt;
            end
            default: begin
                state_next = RUN;
                wcnt_next  = 8'd0;
            end
        endcase
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if ((state == FAULT) || mem_stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            // The ID instruction is wrong-path, so any load-use match on it is moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (!pc_write && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (if_id_flush && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning the number of consecutive memory-stall cycles before fault; legal range is 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports id_rs and id_rt, input, 5 bits each: source registers of the instruction in ID.
REQ-005 SHALL have port ex_mem_read, input, 1 bit: the instruction in EX is a load.
REQ-006 SHALL have port ex_write_reg_addr, input, 5 bits: destination register of the instruction in EX.
REQ-007 SHALL have port ex_branch_taken, input, 1 bit: a branch or jump resolved taken in EX.
REQ-008 SHALL have ports mem_req and mem_ready, input, 1 bit each: the MEM-stage instruction accesses data memory, and memory completes the access this cycle.
REQ-009 SHALL have ports pc_write, if_id_write and ex_mem_write, output, 1 bit each: load enables for the PC, IF/ID, ID/EX and EX/MEM; ex_mem_write gates both ID/EX and EX/MEM.
REQ-010 SHALL have ports if_id_flush and id_ex_flush, output, 1 bit each: the stage register captures a bubble with all control bits 0.
REQ-011 SHALL have port mem_wb_bubble, output, 1 bit: MEM/WB captures reg_write=0 and mem_to_reg=0.
REQ-012 SHALL have port mem_timeout, output, 1 bit: sticky fault flag.

Function
REQ-013 SHALL have FSM states RUN, MEM_WAIT and FAULT, plus an 8-bit wait counter wcnt; all outputs except mem_timeout and the perf counters are combinational from state and current inputs.
REQ-014 SHALL define mem_stall = mem_req && !mem_ready, evaluated in RUN or MEM_WAIT.
REQ-015 SHALL drive the following on a mem_stall cycle: pc_write=0, if_id_write=0, ex_mem_write=0, mem_wb_bubble=1, and both flushes=0.
REQ-016 SHALL define load_use = ex_mem_read && ex_write_reg_addr!=0 && (ex_write_reg_addr==id_rs || ex_write_reg_addr==id_rt).
REQ-017 SHALL, on load_use without mem_stall and without ex_branch_taken, drive pc_write=0, if_id_write=0, id_ex_flush=1 and ex_mem_write=1 for exactly one cycle, with no state change.
REQ-018 SHALL, on ex_branch_taken without mem_stall, drive if_id_flush=1, id_ex_flush=1 and pc_write=1; the branch overrides load_use because the ID instruction is wrong-path.
REQ-019 SHALL apply the priority FAULT > mem_stall > ex_branch_taken > load_use; a branch held during a stall is flushed in the release cycle.
REQ-020 SHALL drive all enables=1, flushes=0 and mem_wb_bubble=0 when no condition is active.
REQ-021 SHALL update wcnt as follows: on a mem_stall cycle, wcnt<=wcnt+1; if wcnt+1==MEM_TIMEOUT, next state is FAULT, else MEM_WAIT.
REQ-022 SHALL, in MEM_WAIT with mem_ready=1, advance the pipeline in that same cycle (REQ-017/018/020 rules apply), set wcnt<=0 and move to RUN.
REQ-023 SHALL treat mem_req dropping in MEM_WAIT the same as ready: go to RUN and set wcnt<=0.
REQ-024 SHALL, in FAULT, drive pc_write=0, if_id_write=0, ex_mem_write=0, mem_wb_bubble=1 and flushes=0, and set mem_timeout=1; FAULT is left only by reset, regardless of inputs.
REQ-025 SHALL keep wcnt at 0 in RUN whenever there is no mem_stall.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, set state=RUN, wcnt=0, mem_timeout=0 and perf counters=0, from any state including mid-MEM_WAIT and FAULT.
REQ-027 SHALL produce, in the first cycle after reset with idle inputs, pc_write=1, if_id_write=1, ex_mem_write=1, if_id_flush=0, id_ex_flush=0, mem_wb_bubble=0 and mem_timeout=0.
REQ-028 SHALL have reset override all other inputs in the same cycle.

Configuration
REQ-029 SHALL recognise macro PIPELINE_CTRL_PERF_EN.
REQ-030 SHALL, when the macro is defined, add 32-bit outputs stall_count and flush_count.
REQ-031 SHALL increment stall_count on each cycle with pc_write=0 and increment flush_count on each cycle with if_id_flush=1; both counters saturate at 0xFFFFFFFF and reset to 0.
REQ-032 SHALL, when the macro is undefined, omit these ports and their logic, with all other behaviour identical.

Verification
REQ-033 SHALL cover load-use: ex_mem_read=1, ex_write_reg_addr=5, id_rs=5 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; with ex_write_reg_addr=0, no stall.
REQ-034 SHALL cover branch plus load-use: ex_branch_taken=1 with a load-use match in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1.
REQ-035 SHALL cover memory wait: mem_req=1 with mem_ready low for 3 cycles, then high -> 3 cycles of all enables=0 and mem_wb_bubble=1, advance in cycle 4, state RUN.
REQ-036 SHALL cover timeout: MEM_TIMEOUT=4, mem_req=1 and mem_ready=0 held -> 4 stall cycles, then FAULT with mem_timeout=1 held while inputs toggle; reset returns to RUN and clears mem_timeout.
REQ-037 SHALL cover reset mid-wait: reset asserted in the 2nd MEM_WAIT cycle -> next cycle state=RUN and wcnt=0; with mem_req still 1 and mem_ready=0, a new stall starts at wcnt=1.
REQ-038 SHALL cover perf counters (macro defined): 2 load-use stalls and 1 taken branch -> stall_count=2, flush_count=1.
